vc_rr_arbiter: RTL
==================

# vc_rr_arbiter

Multi-channel valid/credit to valid/ready arbiter. Accepts NUM_CH independent valid/credit sender streams, buffers each in its own CREDIT_NUM-deep FIFO, and schedules them round-robin onto one shared valid/ready master port. Each beat is tagged with its source channel. The block sits between several credit-based producers and a single ready-based consumer, and replaces per-channel converters plus an external mux.

## Interface
Parameters:
- DATA_WIDTH, 8, payload width
- CREDIT_NUM, 2, per-channel FIFO depth and initial credit count (≥1)
- NUM_CH, 4, number of sender channels (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_data_i  in  NUM_CH×DATA_WIDTH  per-channel payload, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- s_valid_i  in  NUM_CH  per-channel push strobe, one beat per cycle
- s_credit_o  out  NUM_CH  per-channel credit pulse, one credit per asserted cycle
- m_data_o  out  DATA_WIDTH  granted channel's FIFO head
- m_ch_o  out  CH_W  granted channel index, CH_W = max(1,$clog2(NUM_CH))
- m_valid_o  out  1  beat available
- m_ready_i  in  1  consumer accepts; transfer = m_valid_o && m_ready_i

## Operation
- Per channel: FIFO push on s_valid_i[c]; pop on transfer with m_ch_o == c.
- Credit counter per channel, width $clog2(CREDIT_NUM)+1, reset CREDIT_NUM. s_credit_o[c] = (cnt[c] != 0). Each cycle: +1 on pop of c, −1 when s_credit_o[c]; both → unchanged. Counter never exceeds CREDIT_NUM.
- Arbiter FSM, two states:
  - ARB: sel = first non-empty channel searching from rr_ptr upward, wrapping NUM_CH−1 → 0. m_valid_o = any non-empty. Transfer → rr_ptr <= (sel+1) mod NUM_CH, stay ARB. Valid without ready → grant_q <= sel, go HOLD.
  - HOLD: present grant_q; m_valid_o=1, m_data_o/m_ch_o stable. Transfer → rr_ptr <= (grant_q+1) mod NUM_CH, go ARB.
- No valid with ready low ever changes channel or data (lock guarantees stability).
- Senders obey credits, so FIFOs never overflow. A push into a full FIFO is a protocol violation: the beat is dropped and FIFO state is unchanged.
- Reset mid-operation: FIFOs emptied, in-flight beats lost, FSM=ARB, rr_ptr=0, credit counters reload and re-issue CREDIT_NUM pulses.

## Timing
- Reset values: m_valid_o=0, m_ch_o=0, m_data_o=don't-care (FIFO head), s_credit_o=all ones (cnt=CREDIT_NUM).
- After reset each channel sees CREDIT_NUM consecutive credit pulses starting cycle 0.
- Push at edge N → beat eligible for m_valid_o in cycle N+1 (1-cycle latency).
- Pop at edge N → s_credit_o[c] high in cycle N+1 (if cnt was 0), i.e. credit returns 1 cycle after transfer.
- Throughput: 1 beat/cycle aggregate; with all channels backlogged, grants rotate c, c+1, … one per cycle.
- Pop and push same channel, same cycle: both occur; a full FIFO with simultaneous pop accepts the push.

## Configuration
- VC_RR_ARBITER_OVF_CHECK_EN defined: adds port err_ovf_o out NUM_CH. err_ovf_o[c] is a sticky flag, set the cycle after s_valid_i[c] hits a full FIFO (c) without a same-cycle pop, and cleared only by reset (reset value 0).
- Undefined: port and logic absent; overflow is silently dropped as above.

## Structure
- Package vc_arb_pkg: CH_W and CNT_W helper functions, arb_state_e enum {ARB, HOLD}, rr next-index function.
- Sub-module: existing fifo (DATA_WIDTH, DEPTH=CREDIT_NUM; clk_i, arstn_i, push_i, pop_i, data_i, data_o, full_o, empty_o), instantiated NUM_CH times via generate. Arbiter and credit counters live in the top.

## Test plan
- Reset, no traffic → s_credit_o=4'b1111 for 2 cycles (CREDIT_NUM=2), then 0. m_valid_o=0 throughout.
- Channels 0..3 each push 2 beats (0xA0+c, 0xB0+c), m_ready_i=1 → output order ch 0,1,2,3,0,1,2,3 with matching data. Each channel gets one credit 1 cycle after each of its pops.
- ch2 beat 0x55 with m_ready_i=0 for 5 cycles while ch0 pushes → m_ch_o=2, m_data_o=0x55 held. After ready, ch0 is served next.
- rr_ptr=3, only ch1 and ch3 non-empty → ch3 granted first, then ch1 (wrap).
- Sender ignores credits and pushes a 3rd beat into full ch1 → beat dropped. With VC_RR_ARBITER_OVF_CHECK_EN, err_ovf_o[1]=1 next cycle and stays set.
- Assert rst_n low during HOLD on ch2 → m_valid_o=0 immediately. After release, the credit burst repeats and no stale data appears.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared helpers for the round-robin credit/ready arbiter.
package vc_arb_pkg;

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int credits);
    return $clog2(credits) + 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// NUM_CH valid/credit senders -> per-channel FIFOs -> round-robin onto one valid/ready port.
// Optional VC_RR_ARBITER_OVF_CHECK_EN adds sticky per-channel overflow flags (err_ovf_o).
module vc_rr_arbiter
  import vc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2,
  parameter int NUM_CH     = 4,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_CH-1:0]            s_valid_i,
  output logic [NUM_CH-1:0]            s_credit_o,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [CH_W-1:0]              m_ch_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i
`ifdef VC_RR_ARBITER_OVF_CHECK_EN
  ,
  output logic [NUM_CH-1:0]            err_ovf_o
`endif
);
  localparam int CNT_W = cnt_w(CREDIT_NUM);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] dout;
  logic [NUM_CH-1:0]                 full, empty, pop;
  arb_state_e                        state_q, state_d;
  logic [CH_W-1:0]                   rr_q, rr_d, grant_q, grant_d, sel;
  logic                              found, xfer;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(CREDIT_NUM)) u_fifo (
      .clk_i   (clk),
      .arstn_i (rst_n),
      .push_i  (s_valid_i[c]),
      .pop_i   (pop[c]),
      .data_i  (s_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .data_o  (dout[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );

    assign pop[c]        = xfer && (m_ch_o == CH_W'(c));
    assign s_credit_o[c] = (cnt_q != '0);

    // Counter holds credits not yet handed back to the sender.
    always_comb begin
      cnt_d = cnt_q;
      if (pop[c] && !s_credit_o[c])      cnt_d = cnt_q + CNT_W'(1);
      else if (!pop[c] && s_credit_o[c]) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= CNT_W'(CREDIT_NUM);
      else        cnt_q <= cnt_d;
    end

`ifdef VC_RR_ARBITER_OVF_CHECK_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 ovf_q <= 1'b0;
      else if (s_valid_i[c] && full[c] && !pop[c]) ovf_q <= 1'b1;
    end
    assign err_ovf_o[c] = ovf_q;
`endif
  end

  // First non-empty channel at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !empty[(int'(rr_q) + i) % NUM_CH]) begin
        found = 1'b1;
        sel   = CH_W'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    m_valid_o = 1'b0;
    m_ch_o    = sel;
    case (state_q)
      ARB: begin
        m_valid_o = found;
        if (found) begin
          if (m_ready_i) begin
            rr_d = CH_W'(rr_next(int'(sel), NUM_CH));
          end else begin
            grant_d = sel;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        m_valid_o = 1'b1;
        m_ch_o    = grant_q;
        if (m_ready_i) begin
          rr_d    = CH_W'(rr_next(int'(grant_q), NUM_CH));
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign xfer     = m_valid_o && m_ready_i;
  assign m_data_o = dout[m_ch_o];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

endmodule
